// File: rtl/simplez_core_if.sv
// Memory bus between the Simplez core and its external synchronous RAM.
// The core drives address, strobes and write data. The RAM returns read
// data one cycle after a read strobe.
interface simplez_core_if #(
  parameter int DATAW = 12,
  parameter int ADDRW = 9
);
  logic [ADDRW-1:0] mem_addr;
  logic             mem_rd;
  logic             mem_wr;
  logic [DATAW-1:0] mem_wdata;
  logic [DATAW-1:0] mem_rdata;

  modport master (
    output mem_addr, mem_rd, mem_wr, mem_wdata,
    input  mem_rdata
  );

  modport slave (
    input  mem_addr, mem_rd, mem_wr, mem_wdata,
    output mem_rdata
  );
endinterface

// File: rtl/simplez_core.sv
// Simplez execution core: an eight-instruction accumulator machine.
// It fetches from an external 1-cycle-latency RAM. It supports single-step
// pausing and resuming after HALT.
module simplez_core #(
  parameter int DATAW    = 12,
  parameter int ADDRW    = 9,
  parameter int RESET_PC = 0,
  parameter int LEDW     = 4
) (
  input  logic             clk,
  input  logic             rstn,
  simplez_core_if.master   mem,
  input  logic             step_mode,
  input  logic             step,
  input  logic             cont,
  output logic             stop,
  output logic             waiting,
  output logic [LEDW-1:0]  leds,
  output logic [ADDRW-1:0] pc,
  output logic [DATAW-1:0] ac
);

  typedef enum logic [2:0] {
    OP_ST, OP_LD, OP_ADD, OP_BR, OP_BZ, OP_CLR, OP_DEC, OP_HALT
  } opcode_t;

  typedef enum logic [2:0] {
    S_I0, S_I1, S_O0, S_O1, S_WAIT, S_HALTED
  } state_t;

  localparam logic [ADDRW-1:0] RESET_CP = ADDRW'(RESET_PC);

  state_t           state, state_nxt, end_state;
  logic [ADDRW-1:0] cp, cp_nxt;
  logic [DATAW-1:0] acc, acc_nxt;
  logic [DATAW-1:0] ri, ri_nxt;
  logic [ADDRW-1:0] addr;
  logic             rd, wr;
  opcode_t          op_in, op_ri;
  logic [ADDRW-1:0] cd_in, cd_ri;

  // Fetched word is decoded straight off the bus in I1. The operand phase
  // uses the copy latched in RI.
  assign op_in = opcode_t'(mem.mem_rdata[DATAW-1 -: 3]);
  assign cd_in = mem.mem_rdata[ADDRW-1:0];
  assign op_ri = opcode_t'(ri[DATAW-1 -: 3]);
  assign cd_ri = ri[ADDRW-1:0];

  // State, program counter, accumulator and instruction register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= S_I0;
      cp    <= RESET_CP;
      acc   <= '0;
      ri    <= '0;
    end else begin
      state <= state_nxt;
      cp    <= cp_nxt;
      acc   <= acc_nxt;
      ri    <= ri_nxt;
    end
  end

  // Sequencing, execution and memory strobes for the current state
  always_comb begin
    state_nxt = state;
    cp_nxt    = cp;
    acc_nxt   = acc;
    ri_nxt    = ri;
    addr      = cp;
    rd        = 1'b0;
    wr        = 1'b0;
    end_state = step_mode ? S_WAIT : S_I0;
    case (state)
      S_I0: begin
        rd        = 1'b1;
        state_nxt = S_I1;
      end
      S_I1: begin
        ri_nxt    = mem.mem_rdata;
        cp_nxt    = cp + ADDRW'(1);
        state_nxt = end_state;
        case (op_in)
          OP_CLR:  acc_nxt = '0;
          OP_DEC:  acc_nxt = acc - DATAW'(1);
          OP_BR:   cp_nxt = cd_in;
          OP_BZ:   if (acc == '0) cp_nxt = cd_in;
          OP_HALT: state_nxt = S_HALTED;
          default: state_nxt = S_O0;
        endcase
      end
      S_O0: begin
        addr      = cd_ri;
        state_nxt = S_O1;
        if (op_ri == OP_ST) wr = 1'b1;
        else                rd = 1'b1;
      end
      S_O1: begin
        state_nxt = end_state;
        case (op_ri)
          OP_LD:   acc_nxt = mem.mem_rdata;
          OP_ADD:  acc_nxt = acc + mem.mem_rdata;
          default: acc_nxt = acc;
        endcase
      end
      S_WAIT: begin
        if (step || !step_mode) state_nxt = S_I0;
      end
      S_HALTED: begin
        if (cont) state_nxt = S_I0;
      end
      default: state_nxt = S_I0;
    endcase
  end

  // Strobes are gated by reset so that an in-flight access is dropped at once
  assign mem.mem_addr  = addr;
  assign mem.mem_rd    = rd & rstn;
  assign mem.mem_wr    = wr & rstn;
  assign mem.mem_wdata = acc;

  assign stop    = (state == S_HALTED);
  assign waiting = (state == S_WAIT);
  assign leds    = ri[LEDW-1:0];
  assign pc      = cp;
  assign ac      = acc;

endmodule

// File: tb/tb_simplez_core.sv
// Bench for simplez_core. It provides a behavioural RAM and an ISA-level
// reference interpreter, and runs fixed and random programs through the core.
module tb_simplez_core;
  localparam int DW  = 12;
  localparam int AW  = 9;
  localparam int RPC = 0;
  localparam int LW  = 4;
  localparam logic [2:0] OP_ST = 3'd0, OP_LD = 3'd1, OP_ADD = 3'd2, OP_BR = 3'd3;
  localparam logic [2:0] OP_BZ = 3'd4, OP_CLR = 3'd5, OP_DEC = 3'd6, OP_HALT = 3'd7;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          step_mode = 1'b0;
  logic          step = 1'b0;
  logic          cont = 1'b0;
  logic          stop, waiting;
  logic [LW-1:0] leds;
  logic [AW-1:0] pc;
  logic [DW-1:0] ac;

  int nChecks = 0;
  int nPass = 0;

  simplez_core_if #(.DATAW(DW), .ADDRW(AW)) bus ();

  simplez_core #(.DATAW(DW), .ADDRW(AW), .RESET_PC(RPC), .LEDW(LW)) dut (
    .clk(clk), .rstn(rstn), .mem(bus), .step_mode(step_mode), .step(step),
    .cont(cont), .stop(stop), .waiting(waiting), .leds(leds), .pc(pc), .ac(ac)
  );

  always #5 clk = ~clk;

  // Behavioural RAM with a bench-side load/clear port
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic          ldEn = 1'b0;
  logic          clrEn = 1'b0;
  logic [AW-1:0] ldAddr = '0;
  logic [DW-1:0] ldData = '0;

  always @(posedge clk) begin
    if (clrEn) for (int i = 0; i < (1<<AW); i++) ram[i] <= '0;
    else if (ldEn) ram[ldAddr] <= ldData;
    else if (bus.mem_wr) ram[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_rd) bus.mem_rdata <= ram[bus.mem_addr];
  end

  // Reference machine state
  logic [DW-1:0] mdlMem [0:(1<<AW)-1];
  logic [DW-1:0] mdlAc;
  logic [DW-1:0] mdlRi;
  logic [AW-1:0] mdlPc;
  int            mdlCycles;

  function automatic logic [DW-1:0] ins(input logic [2:0] op, input int cd);
    logic [DW-1:0] w;
    w = '0;
    w[DW-1 -: 3] = op;
    w[AW-1:0] = cd[AW-1:0];
    return w;
  endfunction

  // Instruction-set interpreter: runs until HALT, accumulating cycle cost
  task automatic model_run();
    logic [DW-1:0] w;
    logic [AW-1:0] cd;
    for (int n = 0; n < 4000; n++) begin
      w = mdlMem[mdlPc];
      mdlRi = w;
      cd = w[AW-1:0];
      mdlPc = mdlPc + 1'b1;
      case (w[DW-1 -: 3])
        OP_ST:   begin mdlMem[cd] = mdlAc; mdlCycles += 4; end
        OP_LD:   begin mdlAc = mdlMem[cd]; mdlCycles += 4; end
        OP_ADD:  begin mdlAc = mdlAc + mdlMem[cd]; mdlCycles += 4; end
        OP_BR:   begin mdlPc = cd; mdlCycles += 2; end
        OP_BZ:   begin if (mdlAc == 0) mdlPc = cd; mdlCycles += 2; end
        OP_CLR:  begin mdlAc = 0; mdlCycles += 2; end
        OP_DEC:  begin mdlAc = mdlAc - 1'b1; mdlCycles += 2; end
        default: begin mdlCycles += 2; return; end
      endcase
    end
  endtask

  task automatic reset_and_clear();
    @(negedge clk);
    rstn = 1'b0; step_mode = 1'b0; step = 1'b0; cont = 1'b0;
    clrEn = 1'b1;
    @(negedge clk);
    clrEn = 1'b0;
    for (int i = 0; i < (1<<AW); i++) mdlMem[i] = '0;
    mdlAc = '0; mdlRi = '0; mdlPc = AW'(RPC); mdlCycles = 0;
  endtask

  task automatic load(input int addr, input logic [DW-1:0] data);
    ldEn = 1'b1; ldAddr = addr[AW-1:0]; ldData = data;
    mdlMem[addr[AW-1:0]] = data;
    @(negedge clk);
    ldEn = 1'b0;
  endtask

  task automatic run_to_stop(input int maxCyc, output int cyc, output bit timedOut);
    cyc = 0; timedOut = 1'b1;
    for (int i = 0; i < maxCyc; i++) begin
      @(posedge clk); #1; cyc++;
      if (stop) begin timedOut = 1'b0; break; end
    end
  endtask

  task automatic run_to_wait(input int maxCyc, output int cyc, output bit timedOut);
    cyc = 0; timedOut = 1'b1;
    for (int i = 0; i < maxCyc; i++) begin
      @(posedge clk); #1; cyc++;
      if (waiting) begin timedOut = 1'b0; break; end
    end
  endtask

  task automatic pulse_step();
    @(negedge clk); step = 1'b1;
    @(negedge clk); step = 1'b0;
  endtask

  task automatic pulse_cont();
    @(negedge clk); cont = 1'b1;
    @(negedge clk); cont = 1'b0;
  endtask

  // Reset values and strobe suppression, then the first fetch after release
  task automatic test_reset();
    reset_and_clear();
    load(0, ins(OP_CLR, 0));
    repeat (2) @(posedge clk);
    #1;
    nChecks++; if (pc !== AW'(RPC)) $display("[TB] FAIL reset_pc: got %0h want %0h", pc, RPC); else nPass++;
    nChecks++; if (ac !== '0) $display("[TB] FAIL reset_ac: got %0h want 0", ac); else nPass++;
    nChecks++; if (stop !== 1'b0) $display("[TB] FAIL reset_stop: got %b want 0", stop); else nPass++;
    nChecks++; if (waiting !== 1'b0) $display("[TB] FAIL reset_waiting: got %b want 0", waiting); else nPass++;
    nChecks++; if (leds !== '0) $display("[TB] FAIL reset_leds: got %0h want 0", leds); else nPass++;
    nChecks++; if (bus.mem_rd !== 1'b0) $display("[TB] FAIL reset_rd: got %b want 0", bus.mem_rd); else nPass++;
    nChecks++; if (bus.mem_wr !== 1'b0) $display("[TB] FAIL reset_wr: got %b want 0", bus.mem_wr); else nPass++;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    nChecks++; if (bus.mem_rd !== 1'b1) $display("[TB] FAIL first_fetch_rd: got %b want 1", bus.mem_rd); else nPass++;
    nChecks++; if (bus.mem_addr !== AW'(RPC)) $display("[TB] FAIL first_fetch_addr: got %0h want %0h", bus.mem_addr, RPC); else nPass++;
  endtask

  // LD/ADD/ST/HALT with the classic 5+7 case and random operands
  task automatic test_ld_add_st();
    int cyc; bit to;
    logic [DW-1:0] a, b;
    for (int it = 0; it < 4; it++) begin
      a = (it == 0) ? DW'(5) : DW'($urandom);
      b = (it == 0) ? DW'(7) : DW'($urandom);
      reset_and_clear();
      load(0, ins(OP_LD, 100)); load(1, ins(OP_ADD, 101));
      load(2, ins(OP_ST, 102)); load(3, ins(OP_HALT, $urandom));
      load(100, a); load(101, b);
      model_run();
      rstn = 1'b1;
      run_to_stop(100, cyc, to);
      nChecks++; if (to) $display("[TB] FAIL lds_timeout: no stop within 100 cycles"); else nPass++;
      nChecks++; if (cyc != mdlCycles) $display("[TB] FAIL lds_cycles: got %0d want %0d", cyc, mdlCycles); else nPass++;
      nChecks++; if (ac !== mdlAc) $display("[TB] FAIL lds_ac: got %0h want %0h", ac, mdlAc); else nPass++;
      nChecks++; if (pc !== mdlPc) $display("[TB] FAIL lds_pc: got %0h want %0h", pc, mdlPc); else nPass++;
      nChecks++; if (ram[102] !== mdlMem[102]) $display("[TB] FAIL lds_mem102: got %0h want %0h", ram[102], mdlMem[102]); else nPass++;
      nChecks++; if (leds !== mdlRi[LW-1:0]) $display("[TB] FAIL lds_leds: got %0h want %0h", leds, mdlRi[LW-1:0]); else nPass++;
    end
  endtask

  // CLR/DEC/BZ: not-taken after DEC, taken after CLR, and on a loaded value
  task automatic test_clr_dec_bz();
    int cyc; bit to;
    for (int v = 0; v < 4; v++) begin
      reset_and_clear();
      case (v)
        0: begin load(0, ins(OP_CLR, 0)); load(1, ins(OP_DEC, 0)); load(2, ins(OP_BZ, 10)); load(3, ins(OP_HALT, 0)); end
        1: begin load(0, ins(OP_CLR, 0)); load(1, ins(OP_BZ, 10)); load(2, ins(OP_DEC, 0)); load(3, ins(OP_HALT, 0)); end
        default: begin
          load(0, ins(OP_LD, 60)); load(1, ins(OP_BZ, 10)); load(2, ins(OP_DEC, 0)); load(3, ins(OP_HALT, 0));
          load(60, ($urandom_range(0, 1) == 0) ? DW'(0) : DW'($urandom));
        end
      endcase
      load(10, ins(OP_HALT, 5));
      model_run();
      rstn = 1'b1;
      run_to_stop(100, cyc, to);
      nChecks++; if (to) $display("[TB] FAIL bz_timeout: variant %0d no stop", v); else nPass++;
      nChecks++; if (ac !== mdlAc) $display("[TB] FAIL bz_ac: variant %0d got %0h want %0h", v, ac, mdlAc); else nPass++;
      nChecks++; if (pc !== mdlPc) $display("[TB] FAIL bz_pc: variant %0d got %0h want %0h", v, pc, mdlPc); else nPass++;
      nChecks++; if (cyc != mdlCycles) $display("[TB] FAIL bz_cycles: variant %0d got %0d want %0d", v, cyc, mdlCycles); else nPass++;
    end
  endtask

  // ADD overflow wrap and a branch to the top address wrapping CP to 0
  task automatic test_wrap_overflow();
    int cyc; bit to;
    reset_and_clear();
    load(0, ins(OP_BZ, 20)); load(1, ins(OP_HALT, 0));
    load(20, ins(OP_LD, 50)); load(21, ins(OP_ADD, 51)); load(22, ins(OP_BR, (1<<AW)-1));
    load((1<<AW)-1, ins(OP_ADD, 51));
    load(50, DW'(12'hFFF)); load(51, DW'(12'h002));
    model_run();
    rstn = 1'b1;
    run_to_stop(200, cyc, to);
    nChecks++; if (to) $display("[TB] FAIL wrap_timeout: no stop within 200 cycles"); else nPass++;
    nChecks++; if (ac !== mdlAc) $display("[TB] FAIL wrap_ac: got %0h want %0h", ac, mdlAc); else nPass++;
    nChecks++; if (pc !== mdlPc) $display("[TB] FAIL wrap_pc: got %0h want %0h", pc, mdlPc); else nPass++;
    nChecks++; if (cyc != mdlCycles) $display("[TB] FAIL wrap_cycles: got %0d want %0d", cyc, mdlCycles); else nPass++;
  endtask

  // Random forward-only programs over a small data area
  task automatic test_random_programs();
    int cyc, n, r; bit to;
    logic [2:0] op;
    int cd;
    for (int it = 0; it < 5; it++) begin
      reset_and_clear();
      n = $urandom_range(6, 14);
      for (int i = 0; i < n; i++) begin
        r = $urandom_range(0, 5);
        case (r)
          0: op = OP_ST; 1: op = OP_LD; 2: op = OP_ADD;
          3: op = OP_CLR; 4: op = OP_DEC; default: op = OP_BZ;
        endcase
        cd = (op == OP_BZ) ? $urandom_range(i + 1, n) : 200 + $urandom_range(0, 7);
        load(i, ins(op, cd));
      end
      load(n, ins(OP_HALT, $urandom));
      for (int d = 0; d < 8; d++) load(200 + d, ($urandom_range(0, 3) == 0) ? DW'(0) : DW'($urandom));
      model_run();
      rstn = 1'b1;
      run_to_stop(400, cyc, to);
      nChecks++; if (to) $display("[TB] FAIL rnd_timeout: program %0d no stop", it); else nPass++;
      nChecks++; if (cyc != mdlCycles) $display("[TB] FAIL rnd_cycles: got %0d want %0d", cyc, mdlCycles); else nPass++;
      nChecks++; if (ac !== mdlAc) $display("[TB] FAIL rnd_ac: got %0h want %0h", ac, mdlAc); else nPass++;
      nChecks++; if (pc !== mdlPc) $display("[TB] FAIL rnd_pc: got %0h want %0h", pc, mdlPc); else nPass++;
      nChecks++; if (leds !== mdlRi[LW-1:0]) $display("[TB] FAIL rnd_leds: got %0h want %0h", leds, mdlRi[LW-1:0]); else nPass++;
      for (int d = 0; d < 8; d++) begin
        nChecks++; if (ram[200 + d] !== mdlMem[200 + d]) $display("[TB] FAIL rnd_mem: addr %0d got %0h want %0h", 200 + d, ram[200 + d], mdlMem[200 + d]); else nPass++;
      end
    end
  endtask

  // Single-step: pause after each instruction, step releases exactly one
  task automatic test_step_mode();
    int cyc; bit to;
    reset_and_clear();
    load(0, ins(OP_CLR, 0)); load(1, ins(OP_DEC, 0)); load(2, ins(OP_DEC, 0)); load(3, ins(OP_HALT, 0));
    step_mode = 1'b1;
    rstn = 1'b1;
    run_to_wait(20, cyc, to);
    nChecks++; if (to) $display("[TB] FAIL step_timeout1: waiting never rose"); else nPass++;
    nChecks++; if (cyc != 2) $display("[TB] FAIL step_lat1: got %0d want 2", cyc); else nPass++;
    nChecks++; if (pc !== AW'(1)) $display("[TB] FAIL step_pc1: got %0h want 1", pc); else nPass++;
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (waiting !== 1'b1 || pc !== AW'(1)) $display("[TB] FAIL step_hold: waiting %b pc %0h want 1/1", waiting, pc); else nPass++;
    nChecks++; if (bus.mem_rd !== 1'b0 || bus.mem_wr !== 1'b0) $display("[TB] FAIL step_strobes: rd %b wr %b want 0/0", bus.mem_rd, bus.mem_wr); else nPass++;
    pulse_step();
    pulse_step();
    #1;
    nChecks++; if (waiting !== 1'b1) $display("[TB] FAIL step_wait2: got %b want 1", waiting); else nPass++;
    nChecks++; if (pc !== AW'(2)) $display("[TB] FAIL step_pc2: got %0h want 2", pc); else nPass++;
    nChecks++; if (ac !== DW'(12'hFFF)) $display("[TB] FAIL step_ac2: got %0h want fff", ac); else nPass++;
    repeat (2) @(posedge clk);
    #1;
    nChecks++; if (pc !== AW'(2)) $display("[TB] FAIL step_extra: pc got %0h want 2", pc); else nPass++;
    @(negedge clk);
    step_mode = 1'b0;
    run_to_stop(20, cyc, to);
    nChecks++; if (to) $display("[TB] FAIL step_timeout3: no stop after leaving step mode"); else nPass++;
    nChecks++; if (cyc != 5) $display("[TB] FAIL step_lat3: got %0d want 5", cyc); else nPass++;
    nChecks++; if (ac !== DW'(12'hFFE)) $display("[TB] FAIL step_ac3: got %0h want ffe", ac); else nPass++;
    nChecks++; if (pc !== AW'(4)) $display("[TB] FAIL step_pc3: got %0h want 4", pc); else nPass++;
  endtask

  // HALT then cont resumes at the next word; step/step_mode ignored while halted
  task automatic test_halt_cont();
    int cyc; bit to;
    reset_and_clear();
    load(0, ins(OP_DEC, 0)); load(1, ins(OP_HALT, 0)); load(2, ins(OP_DEC, 0));
    load(3, ins(OP_HALT, 0)); load(4, ins(OP_DEC, 0)); load(5, ins(OP_HALT, 0));
    rstn = 1'b1;
    run_to_stop(20, cyc, to);
    nChecks++; if (to || cyc != 4) $display("[TB] FAIL halt_lat: cycles %0d timeout %b want 4/0", cyc, to); else nPass++;
    nChecks++; if (pc !== AW'(2)) $display("[TB] FAIL halt_pc: got %0h want 2", pc); else nPass++;
    pulse_step();
    @(negedge clk); step_mode = 1'b1;
    @(negedge clk); step_mode = 1'b0;
    #1;
    nChecks++; if (stop !== 1'b1 || pc !== AW'(2)) $display("[TB] FAIL halt_ignore: stop %b pc %0h want 1/2", stop, pc); else nPass++;
    pulse_cont();
    #1;
    nChecks++; if (stop !== 1'b0) $display("[TB] FAIL cont_stop: got %b want 0", stop); else nPass++;
    pulse_cont();
    run_to_stop(20, cyc, to);
    nChecks++; if (to) $display("[TB] FAIL cont_timeout: no second halt"); else nPass++;
    nChecks++; if (pc !== AW'(4) || ac !== DW'(12'hFFE)) $display("[TB] FAIL cont_run: pc %0h ac %0h want 4/ffe", pc, ac); else nPass++;
    @(negedge clk); cont = 1'b1; step = 1'b1;
    @(negedge clk); cont = 1'b0; step = 1'b0;
    run_to_stop(20, cyc, to);
    nChecks++; if (to) $display("[TB] FAIL both_timeout: no third halt"); else nPass++;
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (pc !== AW'(6) || ac !== DW'(12'hFFD) || stop !== 1'b1) $display("[TB] FAIL both_once: pc %0h ac %0h stop %b want 6/ffd/1", pc, ac, stop); else nPass++;
  endtask

  // Reset asserted during the ST operand cycle must suppress the write
  task automatic test_reset_mid_st();
    reset_and_clear();
    load(0, ins(OP_LD, 40)); load(1, ins(OP_ST, 41)); load(2, ins(OP_HALT, 0));
    load(40, DW'(12'hABC)); load(41, DW'(12'h123));
    rstn = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    nChecks++; if (bus.mem_wr !== 1'b1) $display("[TB] FAIL midst_reach: mem_wr got %b want 1", bus.mem_wr); else nPass++;
    rstn = 1'b0;
    #1;
    nChecks++; if (bus.mem_wr !== 1'b0) $display("[TB] FAIL midst_wr: got %b want 0", bus.mem_wr); else nPass++;
    nChecks++; if (pc !== AW'(RPC) || ac !== '0) $display("[TB] FAIL midst_regs: pc %0h ac %0h want %0h/0", pc, ac, RPC); else nPass++;
    repeat (3) @(posedge clk);
    #1;
    nChecks++; if (ram[41] !== DW'(12'h123)) $display("[TB] FAIL midst_mem: got %0h want 123", ram[41]); else nPass++;
    @(negedge clk);
    rstn = 1'b1;
    #1;
    nChecks++; if (bus.mem_rd !== 1'b1 || bus.mem_addr !== AW'(RPC)) $display("[TB] FAIL midst_refetch: rd %b addr %0h want 1/%0h", bus.mem_rd, bus.mem_addr, RPC); else nPass++;
  endtask

  initial begin
    test_reset();
    test_ld_add_st();
    test_clr_dec_bz();
    test_wrap_overflow();
    test_random_programs();
    test_step_mode();
    test_halt_cont();
    test_reset_mid_st();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

  initial begin
    #5000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

endmodule
